std_crc_stream: RTL and testbench

Streaming, parametrised CRC engine with handshake. It consumes packet beats of DW bits (1 to 8 bytes) with start/end markers and a partial last beat. It produces one registered CRC result per packet, plus a residue-match flag for FCS checking. It sits beside the MAC datapath as the next-generation replacement for fixed-width combinational CRC32 encoders: it generates the FCS on TX and checks frames on RX.

---
 rtl/std_crc_pkg.sv | 22 ++
 rtl/std_crc_bytes.sv | 24 ++
 rtl/std_crc_stream.sv | 100 ++++++++++
 tb/tb_std_crc_stream.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_crc_pkg.sv
// CRC-32 constants and the reflected single-byte update step shared by the
// streaming CRC engine.
package std_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // LSB-first: the byte enters at bit 0 and each step shifts right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data_byte,
                                             input logic [31:0] poly);
    logic [31:0] c;
    c = crc ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/std_crc_bytes.sv
// Combinational byte-chain: entry k of crc_arr is the CRC after consuming
// bytes 0..k of the beat, starting from seed.
module std_crc_bytes
  import std_crc_pkg::*;
#(
  parameter int          DW   = 64,
  parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
  input  logic [31:0]             seed,
  input  logic [DW-1:0]           data,
  output logic [DW/8-1:0][31:0]   crc_arr
);

  always_comb begin
    logic [31:0] c;
    c = seed;
    crc_arr = '0;
    for (int k = 0; k < DW / 8; k++) begin
      c = crc32_byte(c, data[8*k +: 8], POLY);
      crc_arr[k] = c;
    end
  end

endmodule

// File: rtl/std_crc_stream.sv
// Streaming CRC-32 engine: accumulates packet beats, emits one registered
// result per packet with a residue-match flag, valid/ready on both sides.
module std_crc_stream
  import std_crc_pkg::*;
#(
  parameter int          DW      = 64,
  parameter logic [31:0] POLY    = CRC32_POLY_REFL,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOROUT  = CRC32_XOROUT,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
  localparam int         NB      = DW / 8,
  localparam int         BW      = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [BW-1:0] in_bytes,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   crc_out,
  output logic          crc_ok
);

  logic [31:0]         crc_q, crc_d;
  logic                res_valid_q, res_valid_d;
  logic [31:0]         crc_out_q, crc_out_d;
  logic                crc_ok_q, crc_ok_d;

  logic [31:0]         seed;
  logic [NB-1:0][31:0] crc_arr;
  logic [BW-1:0]       sel;
  logic [31:0]         crc_next;
  logic                accept;

  assign seed = in_sop ? INIT : crc_q;

  std_crc_bytes #(
    .DW   (DW),
    .POLY (POLY)
  ) u_bytes (
    .seed    (seed),
    .data    (in_data),
    .crc_arr (crc_arr)
  );

  // in_bytes == 0 on an eop beat means a full beat, same as non-eop beats.
  always_comb begin
    sel = BW'(NB - 1);
    if (in_eop && (in_bytes != '0) && (int'(in_bytes) < NB)) begin
      sel = in_bytes - 1'b1;
    end
  end

  assign crc_next = crc_arr[sel];
  assign in_ready = !res_valid_q || res_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    crc_d       = crc_q;
    res_valid_d = res_valid_q;
    crc_out_d   = crc_out_q;
    crc_ok_d    = crc_ok_q;
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (accept) begin
      if (in_eop) begin
        crc_out_d   = crc_next ^ XOROUT;
        crc_ok_d    = (crc_next == RESIDUE);
        res_valid_d = 1'b1;
        crc_d       = INIT;
      end else begin
        crc_d = crc_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q       <= INIT;
      res_valid_q <= 1'b0;
      crc_out_q   <= 32'h0;
      crc_ok_q    <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      res_valid_q <= res_valid_d;
      crc_out_q   <= crc_out_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

  assign res_valid = res_valid_q;
  assign crc_out   = crc_out_q;
  assign crc_ok    = crc_ok_q;

endmodule

// File: tb/tb_std_crc_stream.sv
// Bench for std_crc_stream at DW=8, 32 and 64 against a bit-serial CRC-32
// reference model with a per-instance expected-result queue.
module tb_std_crc_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: DW=8, 1: DW=32, 2: DW=64
  logic        v8, rdy8, sop8, eop8, rv8, rr8, ok8;
  logic [7:0]  d8;
  logic [0:0]  nb8;
  logic [31:0] crc8;
  logic        v32, rdy32, sop32, eop32, rv32, rr32, ok32;
  logic [31:0] d32;
  logic [1:0]  nb32;
  logic [31:0] crc32;
  logic        v64, rdy64, sop64, eop64, rv64, rr64, ok64;
  logic [63:0] d64;
  logic [2:0]  nb64;
  logic [31:0] crc64;

  std_crc_stream #(.DW(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_sop(sop8), .in_eop(eop8), .in_bytes(nb8), .res_valid(rv8),
    .res_ready(rr8), .crc_out(crc8), .crc_ok(ok8));

  std_crc_stream #(.DW(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_sop(sop32), .in_eop(eop32), .in_bytes(nb32), .res_valid(rv32),
    .res_ready(rr32), .crc_out(crc32), .crc_ok(ok32));

  std_crc_stream #(.DW(64)) u64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(rdy64), .in_data(d64),
    .in_sop(sop64), .in_eop(eop64), .in_bytes(nb64), .res_valid(rv64),
    .res_ready(rr64), .crc_out(crc64), .crc_ok(ok64));

  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  logic [32:0] exp2[$];
  bit          pend[3];
  logic [32:0] held[3];
  logic [32:0] last[3];
  int          nres[3];
  bit          rr_rand = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: CRC-32 as a bit-serial reflected LFSR over the whole message.
  function automatic logic [31:0] ref_raw(input logic [7:0] q[$]);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = r[0] ^ q[i][b];
        r = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return r;
  endfunction

  function automatic logic [32:0] mk_exp(input logic [7:0] q[$]);
    logic [31:0] r;
    r = ref_raw(q);
    return {r == 32'hDEBB20E3, r ^ 32'hFFFFFFFF};
  endfunction

  function automatic void push_exp(input int i, input logic [32:0] e);
    case (i)
      0: exp0.push_back(e);
      1: exp1.push_back(e);
      default: exp2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic logic [32:0] qpop(input int i);
    case (i)
      0: return exp0.pop_front();
      1: return exp1.pop_front();
      default: return exp2.pop_front();
    endcase
  endfunction

  function automatic logic rdy(input int i);
    case (i)
      0: return rdy8;
      1: return rdy32;
      default: return rdy64;
    endcase
  endfunction

  function automatic void set_rr(input int i, input logic v);
    case (i)
      0: rr8 = v;
      1: rr32 = v;
      default: rr64 = v;
    endcase
  endfunction

  function automatic void clr_valid(input int i);
    case (i)
      0: v8 = 1'b0;
      1: v32 = 1'b0;
      default: v64 = 1'b0;
    endcase
  endfunction

  // Result monitor: a new result is checked once against the model, then
  // must hold steady until the cycle it is consumed.
  task automatic mon(input int i, input logic rv, input logic rr,
                     input logic [31:0] crc, input logic ok);
    logic [32:0] e;
    if (!rv) begin
      pend[i] = 0;
    end else if (!pend[i]) begin
      chk($sformatf("u%0d result expected", i), 64'(qsize(i) > 0), 64'd1);
      if (qsize(i) > 0) begin
        e = qpop(i);
        chk($sformatf("u%0d crc_out", i), 64'(crc), 64'(e[31:0]));
        chk($sformatf("u%0d crc_ok", i), 64'(ok), 64'(e[32]));
      end
      held[i] = {ok, crc};
      last[i] = {ok, crc};
      nres[i]++;
      pend[i] = 1;
    end else begin
      chk($sformatf("u%0d result hold", i), 64'({ok, crc}), 64'(held[i]));
    end
    if (rv && rr) pend[i] = 0;
  endtask

  always @(negedge clk) begin
    mon(0, rv8, rr8, crc8, ok8);
    mon(1, rv32, rr32, crc32, ok32);
    mon(2, rv64, rr64, crc64, ok64);
  end

  // Present one beat at a negedge, wait for in_ready, let the accepting edge pass.
  task automatic beat(input int i, input logic [63:0] d, input bit sop,
                      input bit eop, input int nb);
    int w;
    w = 0;
    @(negedge clk);
    case (i)
      0: begin v8 = 1; d8 = d[7:0]; sop8 = sop; eop8 = eop; nb8 = 1'(nb); end
      1: begin v32 = 1; d32 = d[31:0]; sop32 = sop; eop32 = eop; nb32 = 2'(nb); end
      default: begin v64 = 1; d64 = d; sop64 = sop; eop64 = eop; nb64 = 3'(nb); end
    endcase
    while (!rdy(i)) begin
      w++;
      if (w > 200) begin
        chk($sformatf("u%0d in_ready timeout", i), 64'(rdy(i)), 64'd1);
        break;
      end
      @(posedge clk); #1;
      if (rr_rand) set_rr(i, 1'($urandom_range(0, 1)));
      else if (w >= 4) set_rr(i, 1'b1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    clr_valid(i);
    if (rr_rand) set_rr(i, 1'($urandom_range(0, 1)));
  endtask

  task automatic pkt(input int i, input logic [7:0] q[$], input bit sop, input bit eop);
    int nbb, n, pos, cnt;
    logic [63:0] d;
    nbb = (i == 0) ? 1 : (i == 1) ? 4 : 8;
    n = q.size();
    pos = 0;
    while (pos < n) begin
      cnt = (n - pos < nbb) ? n - pos : nbb;
      d = {$urandom, $urandom};
      for (int k = 0; k < cnt; k++) d[8*k +: 8] = q[pos + k];
      beat(i, d, sop && (pos == 0), eop && (pos + cnt == n), (cnt == nbb) ? 0 : cnt);
      pos += cnt;
    end
    if (eop) push_exp(i, mk_exp(q));
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic set_rr_at(input int i, input logic v);
    @(posedge clk); #1;
    set_rr(i, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s9[$];
    logic [7:0] q[$];
    logic [7:0] qa[$];
    int n0, c0, len, idx;

    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reset = 1;
    {v8, sop8, eop8, d8, nb8} = '0;
    {v32, sop32, eop32, d32, nb32} = '0;
    {v64, sop64, eop64, d64, nb64} = '0;
    rr8 = 1; rr32 = 1; rr64 = 1;
    repeat (3) @(posedge clk);
    settle();
    chk("reset res_valid u8", 64'(rv8), 64'd0);
    chk("reset crc_out u8", 64'(crc8), 64'd0);
    chk("reset crc_ok u64", 64'(ok64), 64'd0);
    chk("reset res_valid u64", 64'(rv64), 64'd0);
    reset = 0;
    settle();
    chk("in_ready after reset u8", 64'(rdy8), 64'd1);
    chk("in_ready after reset u32", 64'(rdy32), 64'd1);
    chk("in_ready after reset u64", 64'(rdy64), 64'd1);

    // "123456789" one byte per beat; result visible right after the eop edge
    pkt(0, s9, 1, 1);
    chk("u8 latency res_valid", 64'(rv8), 64'd1);
    settle();
    chk("u8 check string", 64'(last[0][31:0]), 64'hCBF43926);

    pkt(2, s9, 1, 1);
    settle();
    chk("u64 check string", 64'(last[2][31:0]), 64'hCBF43926);
    chk("u64 check string ok", 64'(last[2][32]), 64'd0);

    // frame with appended FCS checks good; any single flipped bit breaks it
    q = s9;
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    pkt(1, q, 1, 1);
    settle();
    chk("u32 residue ok", 64'(last[1][32]), 64'd1);
    for (int t = 0; t < 3; t++) begin
      qa = q;
      idx = $urandom_range(0, 12);
      qa[idx] = qa[idx] ^ (8'h01 << $urandom_range(0, 7));
      pkt(1, qa, 1, 1);
      settle();
      chk("u32 flipped bit ok", 64'(last[1][32]), 64'd0);
    end

    // backpressure: second packet stalls behind an unconsumed result
    n0 = nres[2];
    set_rr_at(2, 0);
    q.delete();
    for (int k = 0; k < 12; k++) q.push_back(8'($urandom));
    pkt(2, q, 1, 1);
    settle();
    chk("bp res_valid held", 64'(rv64), 64'd1);
    chk("bp in_ready low", 64'(rdy64), 64'd0);
    repeat (3) settle();
    q.delete();
    for (int k = 0; k < 20; k++) q.push_back(8'($urandom));
    pkt(2, q, 1, 1);
    repeat (2) settle();
    chk("bp result count", 64'(nres[2] - n0), 64'd2);

    // sop mid-packet discards the partial accumulation
    n0 = nres[0];
    qa.delete();
    for (int k = 0; k < 3; k++) qa.push_back(s9[k]);
    pkt(0, qa, 1, 0);
    pkt(0, s9, 1, 1);
    repeat (2) settle();
    chk("abort result count", 64'(nres[0] - n0), 64'd1);
    chk("abort restart crc", 64'(last[0][31:0]), 64'hCBF43926);

    // reset mid-packet on u8 while u64 holds a pending result
    set_rr_at(2, 0);
    pkt(2, s9, 1, 1);
    qa.delete();
    for (int k = 0; k < 4; k++) qa.push_back(s9[k]);
    pkt(0, qa, 1, 0);
    @(negedge clk); #2;
    reset = 1;
    #1;
    chk("async reset res_valid u64", 64'(rv64), 64'd0);
    chk("async reset crc_out u64", 64'(crc64), 64'd0);
    chk("async reset res_valid u8", 64'(rv8), 64'd0);
    set_rr_at(2, 1);
    settle();
    reset = 0;
    pkt(0, s9, 0, 1);
    pkt(2, s9, 1, 1);
    settle();
    chk("post-reset u8 crc", 64'(last[0][31:0]), 64'hCBF43926);
    chk("post-reset u64 crc", 64'(last[2][31:0]), 64'hCBF43926);

    // back-to-back single-beat packets at full rate
    q.delete();
    q.push_back(8'h00);
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      pkt(0, q, 1, 1);
      chk("b2b res_valid", 64'(rv8), 64'd1);
    end
    chk("b2b cycles", 64'(cyc - c0), 64'd8);
    settle();
    chk("b2b crc", 64'(last[0][31:0]), 64'hD202EF8D);

    // randomized packets, widths, aborts, missing sop and backpressure
    rr_rand = 1;
    for (int t = 0; t < 40; t++) begin
      idx = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) begin
        qa.delete();
        len = $urandom_range(1, 12);
        for (int k = 0; k < len; k++) qa.push_back(8'($urandom));
        pkt(idx, qa, 1, 0);
        q.delete();
        len = $urandom_range(1, 24);
        for (int k = 0; k < len; k++) q.push_back(8'($urandom));
        pkt(idx, q, 1, 1);
      end else begin
        q.delete();
        len = $urandom_range(1, 24);
        for (int k = 0; k < len; k++) q.push_back(8'($urandom));
        pkt(idx, q, ($urandom_range(0, 3) != 0), 1);
      end
    end
    rr_rand = 0;
    @(posedge clk); #1;
    rr8 = 1; rr32 = 1; rr64 = 1;
    repeat (4) settle();
    chk("drain u8", 64'(qsize(0)), 64'd0);
    chk("drain u32", 64'(qsize(1)), 64'd0);
    chk("drain u64", 64'(qsize(2)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
